// File: rtl/decode_dispatch_ctrl_pkg.sv
// Shared decode constants: opcode field values, dispatch op codes,
// instruction field slicers and the default ROB tag width.
package decode_dispatch_ctrl_pkg;

    localparam int ROB_WIDTH_DEF = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [6:0] {
        OP_NULL  = 7'd0,
        OP_LUI   = 7'd1,
        OP_AUIPC = 7'd2,
        OP_JAL   = 7'd3,
        OP_JALR  = 7'd4,
        OP_BEQ   = 7'd5,
        OP_BNE   = 7'd6,
        OP_BLT   = 7'd7,
        OP_BGE   = 7'd8,
        OP_BLTU  = 7'd9,
        OP_BGEU  = 7'd10,
        OP_LB    = 7'd11,
        OP_LH    = 7'd12,
        OP_LW    = 7'd13,
        OP_LBU   = 7'd14,
        OP_LHU   = 7'd15,
        OP_SB    = 7'd16,
        OP_SH    = 7'd17,
        OP_SW    = 7'd18,
        OP_ADDI  = 7'd19,
        OP_SLTI  = 7'd20,
        OP_SLTIU = 7'd21,
        OP_XORI  = 7'd22,
        OP_ORI   = 7'd23,
        OP_ANDI  = 7'd24,
        OP_SLLI  = 7'd25,
        OP_SRLI  = 7'd26,
        OP_SRAI  = 7'd27,
        OP_ADD   = 7'd28,
        OP_SUB   = 7'd29,
        OP_SLL   = 7'd30,
        OP_SLT   = 7'd31,
        OP_SLTU  = 7'd32,
        OP_XOR   = 7'd33,
        OP_SRL   = 7'd34,
        OP_SRA   = 7'd35,
        OP_OR    = 7'd36,
        OP_AND   = 7'd37
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_HELD      = 2'd1,
        ST_WAIT_JALR = 2'd2
    } state_e;

    function automatic logic [6:0] f_opc(input logic [31:0] i);
        return i[6:0];
    endfunction

    function automatic logic [2:0] f_funct3(input logic [31:0] i);
        return i[14:12];
    endfunction

    function automatic logic [6:0] f_funct7(input logic [31:0] i);
        return i[31:25];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] i);
        return i[11:7];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] i);
        return i[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] i);
        return i[24:20];
    endfunction

endpackage

// File: rtl/decode_dispatch_ctrl_if.sv
// Instruction-queue, back-end status and dispatch bundle between
// the decode/dispatch controller and its surroundings.
interface decode_dispatch_ctrl_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 iq_valid_in;
    logic [31:0]          iq_inst_in;
    logic [31:0]          iq_pc_in;
    logic                 iq_pred_in;
    logic                 iq_ready_out;
    logic                 rob_full_in;
    logic                 rs_full_in;
    logic                 lsb_full_in;
    logic [ROB_WIDTH-1:0] rob_tail_in;
    logic                 jalr_done_in;
    logic                 disp_valid_out;
    logic                 disp_to_rs_out;
    logic                 disp_to_lsb_out;
    logic [6:0]           disp_op_out;
    logic [4:0]           disp_rd_out;
    logic [4:0]           disp_rs1_out;
    logic [4:0]           disp_rs2_out;
    logic [31:0]          disp_imm_out;
    logic [31:0]          disp_pc_out;
    logic                 disp_pred_out;
    logic [ROB_WIDTH-1:0] disp_tag_out;
    logic                 fetch_hold_out;
    logic                 illegal_out;

    modport master (
        input  iq_valid_in, iq_inst_in, iq_pc_in, iq_pred_in,
        input  rob_full_in, rs_full_in, lsb_full_in,
        input  rob_tail_in, jalr_done_in,
        output iq_ready_out,
        output disp_valid_out, disp_to_rs_out, disp_to_lsb_out,
        output disp_op_out, disp_rd_out, disp_rs1_out, disp_rs2_out,
        output disp_imm_out, disp_pc_out, disp_pred_out, disp_tag_out,
        output fetch_hold_out, illegal_out
    );

    modport slave (
        output iq_valid_in, iq_inst_in, iq_pc_in, iq_pred_in,
        output rob_full_in, rs_full_in, lsb_full_in,
        output rob_tail_in, jalr_done_in,
        input  iq_ready_out,
        input  disp_valid_out, disp_to_rs_out, disp_to_lsb_out,
        input  disp_op_out, disp_rd_out, disp_rs1_out, disp_rs2_out,
        input  disp_imm_out, disp_pc_out, disp_pred_out, disp_tag_out,
        input  fetch_hold_out, illegal_out
    );
endinterface

// File: rtl/decode_dispatch_ctrl_parser.sv
// Combinational RV32I instruction parser: op code, register fields,
// immediate and routing hints. Unknown encodings decode to OP_NULL.
module decode_dispatch_ctrl_parser
    import decode_dispatch_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [6:0]  op_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        is_ls_o,
    output logic        is_jalr_o
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign f3    = f_funct3(inst_i);
    assign f7    = f_funct7(inst_i);
    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25],
                    inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20],
                    inst_i[30:21], 1'b0};

    // Decode op code and pick the fields that the format actually carries
    always_comb begin
        op_o  = OP_NULL;
        rd_o  = '0;
        rs1_o = '0;
        rs2_o = '0;
        imm_o = '0;
        case (f_opc(inst_i))
            OPC_LUI: begin
                op_o  = OP_LUI;
                rd_o  = f_rd(inst_i);
                imm_o = imm_u;
            end
            OPC_AUIPC: begin
                op_o  = OP_AUIPC;
                rd_o  = f_rd(inst_i);
                imm_o = imm_u;
            end
            OPC_JAL: begin
                op_o  = OP_JAL;
                rd_o  = f_rd(inst_i);
                imm_o = imm_j;
            end
            OPC_JALR: begin
                if (f3 == 3'b000) op_o = OP_JALR;
                rd_o  = f_rd(inst_i);
                rs1_o = f_rs1(inst_i);
                imm_o = imm_i;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  op_o = OP_BEQ;
                    3'b001:  op_o = OP_BNE;
                    3'b100:  op_o = OP_BLT;
                    3'b101:  op_o = OP_BGE;
                    3'b110:  op_o = OP_BLTU;
                    3'b111:  op_o = OP_BGEU;
                    default: op_o = OP_NULL;
                endcase
                rs1_o = f_rs1(inst_i);
                rs2_o = f_rs2(inst_i);
                imm_o = imm_b;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  op_o = OP_LB;
                    3'b001:  op_o = OP_LH;
                    3'b010:  op_o = OP_LW;
                    3'b100:  op_o = OP_LBU;
                    3'b101:  op_o = OP_LHU;
                    default: op_o = OP_NULL;
                endcase
                rd_o  = f_rd(inst_i);
                rs1_o = f_rs1(inst_i);
                imm_o = imm_i;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  op_o = OP_SB;
                    3'b001:  op_o = OP_SH;
                    3'b010:  op_o = OP_SW;
                    default: op_o = OP_NULL;
                endcase
                rs1_o = f_rs1(inst_i);
                rs2_o = f_rs2(inst_i);
                imm_o = imm_s;
            end
            OPC_OPIMM: begin
                case (f3)
                    3'b000: op_o = OP_ADDI;
                    3'b010: op_o = OP_SLTI;
                    3'b011: op_o = OP_SLTIU;
                    3'b100: op_o = OP_XORI;
                    3'b110: op_o = OP_ORI;
                    3'b111: op_o = OP_ANDI;
                    3'b001: op_o = (f7 == 7'h00) ? OP_SLLI : OP_NULL;
                    3'b101: begin
                        if (f7 == 7'h00)      op_o = OP_SRLI;
                        else if (f7 == 7'h20) op_o = OP_SRAI;
                        else                  op_o = OP_NULL;
                    end
                    default: op_o = OP_NULL;
                endcase
                rd_o  = f_rd(inst_i);
                rs1_o = f_rs1(inst_i);
                imm_o = imm_i;
            end
            OPC_OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  op_o = OP_ADD;
                        3'b001:  op_o = OP_SLL;
                        3'b010:  op_o = OP_SLT;
                        3'b011:  op_o = OP_SLTU;
                        3'b100:  op_o = OP_XOR;
                        3'b101:  op_o = OP_SRL;
                        3'b110:  op_o = OP_OR;
                        default: op_o = OP_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    case (f3)
                        3'b000:  op_o = OP_SUB;
                        3'b101:  op_o = OP_SRA;
                        default: op_o = OP_NULL;
                    endcase
                end
                rd_o  = f_rd(inst_i);
                rs1_o = f_rs1(inst_i);
                rs2_o = f_rs2(inst_i);
            end
            default: op_o = OP_NULL;
        endcase
    end

    assign is_ls_o   = (op_o >= OP_LB) && (op_o <= OP_SW);
    assign is_jalr_o = (op_o == OP_JALR);

endmodule

// File: rtl/decode_dispatch_ctrl.sv
// Decode/dispatch sequencer: one-entry holding register, parser and a
// three-state controller that routes to ROB plus RS or LSB.
module decode_dispatch_ctrl
    import decode_dispatch_ctrl_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    decode_dispatch_ctrl_if.master bus
);
    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        pred_q, pred_d;
    logic        valid_q, valid_d;

    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        is_ls, is_jalr;
    logic        go, held, drop, fire, tgt_full, accept, ready;

    decode_dispatch_ctrl_parser u_parser (
        .inst_i    (inst_q),
        .op_o      (op),
        .rd_o      (rd),
        .rs1_o     (rs1),
        .rs2_o     (rs2),
        .imm_o     (imm),
        .is_ls_o   (is_ls),
        .is_jalr_o (is_jalr)
    );

    assign go       = rst_in && rdy_in && !flush_in;
    assign held     = (state_q == ST_HELD) && valid_q;
    assign tgt_full = is_ls ? bus.lsb_full_in : bus.rs_full_in;
    assign drop     = go && held && (op == OP_NULL);
    assign fire     = go && held && (op != OP_NULL) &&
                      !bus.rob_full_in && !tgt_full;
    assign ready    = go && ((state_q == ST_EMPTY) ||
                             (fire && !is_jalr) || drop);
    assign accept   = ready && bus.iq_valid_in;

    assign bus.iq_ready_out    = ready;
    assign bus.disp_valid_out  = fire;
    assign bus.disp_to_rs_out  = fire && !is_ls;
    assign bus.disp_to_lsb_out = fire && is_ls;
    assign bus.disp_op_out     = op;
    assign bus.disp_rd_out     = rd;
    assign bus.disp_rs1_out    = rs1;
    assign bus.disp_rs2_out    = rs2;
    assign bus.disp_imm_out    = imm;
    assign bus.disp_pc_out     = pc_q;
    assign bus.disp_pred_out   = pred_q;
    assign bus.disp_tag_out    = bus.rob_tail_in;
    assign bus.fetch_hold_out  = (state_q == ST_WAIT_JALR);
    assign bus.illegal_out     = drop;

    // Next state and holding register: flush beats stall beats normal flow
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        pred_d  = pred_q;
        valid_d = valid_q;
        if (flush_in) begin
            valid_d = 1'b0;
            state_d = ST_EMPTY;
        end else if (rdy_in) begin
            case (state_q)
                ST_HELD: begin
                    if (fire && is_jalr) begin
                        valid_d = 1'b0;
                        state_d = ST_WAIT_JALR;
                    end else if (fire || drop) begin
                        valid_d = accept;
                        state_d = accept ? ST_HELD : ST_EMPTY;
                    end
                end
                ST_WAIT_JALR: begin
                    if (bus.jalr_done_in) state_d = ST_EMPTY;
                end
                default: begin
                    if (accept) begin
                        valid_d = 1'b1;
                        state_d = ST_HELD;
                    end
                end
            endcase
            if (accept) begin
                inst_d = bus.iq_inst_in;
                pc_d   = bus.iq_pc_in;
                pred_d = bus.iq_pred_in;
            end
        end
    end

    // Controller state and holding register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_EMPTY;
            inst_q  <= '0;
            pc_q    <= '0;
            pred_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            valid_q <= valid_d;
        end
    end

endmodule
